// File: rtl/tournament_choice_ctrl.sv
// Tournament choice-counter table; optional `CHOICE_FWD_EN folds queued updates into lookups.
// Latency: choice_prediction 1 cycle after an accepted lookup; init runs 2**IDX_W cycles after reset.
// Backpressure: lookup_ready/update_ready low during init or when the update FIFO is full (head drains then).
module tournament_choice_ctrl #(
    parameter int         IDX_W      = 8,
    parameter logic [1:0] INIT_STATE = 2'b01,
    parameter int         UPD_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lookup_v,
    input  logic [IDX_W-1:0] lookup_idx,
    output logic             lookup_ready,
    output logic             choice_v,
    output logic [1:0]       choice_prediction,
    input  logic             update_v,
    input  logic [IDX_W-1:0] update_idx,
    input  logic             global_correct,
    input  logic             local_correct,
    output logic             update_ready,
    output logic             init_done
);
    localparam int ENTRIES = 1 << IDX_W;
    localparam int PTR_W   = $clog2(UPD_DEPTH);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             global_correct;
        logic             local_correct;
    } upd_t;

    state_t           state;
    logic [IDX_W-1:0] init_ptr;
    logic [1:0]       ctr_q [ENTRIES];
    upd_t             fifo_q [UPD_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;

    logic fifo_full;
    logic fifo_empty;
    logic lookup_acc;
    logic update_acc;
    logic drain;
    upd_t head;
    upd_t push_dat;
    logic [1:0] drain_val;
    logic [1:0] lookup_val;

    function automatic logic [1:0] step_ctr(input logic [1:0] c, input logic g, input logic l);
        if (g && !l)
            return (c == 2'b11) ? c : c + 2'd1;
        else if (!g && l)
            return (c == 2'b00) ? c : c - 2'd1;
        else
            return c;
    endfunction

    assign fifo_full    = (count == (PTR_W+1)'(UPD_DEPTH));
    assign fifo_empty   = (count == '0);
    assign lookup_ready = init_done && !fifo_full;
    assign update_ready = init_done && !fifo_full;
    assign lookup_acc   = lookup_v && lookup_ready;
    assign update_acc   = update_v && update_ready;
    // The single table port goes to the head update only when no lookup claims it.
    assign drain        = init_done && !fifo_empty && !lookup_acc;

    assign head      = fifo_q[rd_ptr];
    assign push_dat  = {update_idx, global_correct, local_correct};
    assign drain_val = step_ctr(ctr_q[head.idx], head.global_correct, head.local_correct);

    always_comb begin
        lookup_val = ctr_q[lookup_idx];
`ifdef CHOICE_FWD_EN
        // Walk queued entries oldest-first so the result matches a fully drained table.
        for (int i = 0; i < UPD_DEPTH; i++) begin
            if ((i < int'(count)) && (fifo_q[rd_ptr + PTR_W'(i)].idx == lookup_idx))
                lookup_val = step_ctr(lookup_val,
                                      fifo_q[rd_ptr + PTR_W'(i)].global_correct,
                                      fifo_q[rd_ptr + PTR_W'(i)].local_correct);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == ST_INIT)
                ctr_q[init_ptr] <= INIT_STATE;
            else if (drain)
                ctr_q[head.idx] <= drain_val;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && update_acc)
            fifo_q[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= ST_INIT;
            init_ptr          <= '0;
            init_done         <= 1'b0;
            choice_v          <= 1'b0;
            choice_prediction <= 2'b00;
            rd_ptr            <= '0;
            wr_ptr            <= '0;
            count             <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    init_ptr <= init_ptr + IDX_W'(1);
                    if (init_ptr == {IDX_W{1'b1}}) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end
                end
                default: state <= ST_RUN;
            endcase

            choice_v <= lookup_acc;
            if (lookup_acc)
                choice_prediction <= lookup_val;

            if (update_acc)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (drain)
                rd_ptr <= rd_ptr + PTR_W'(1);

            case ({update_acc, drain})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_tournament_choice_ctrl.sv
// Bench for tournament_choice_ctrl: queue-based reference model checked every cycle,
// directed scenarios pinned with literal expectations, then randomized traffic.
module tb_tournament_choice_ctrl;
    localparam int IDX_W = 4;
    localparam int N     = 16;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             lookup_v;
    logic [IDX_W-1:0] lookup_idx;
    logic             lookup_ready;
    logic             choice_v;
    logic [1:0]       choice_prediction;
    logic             update_v;
    logic [IDX_W-1:0] update_idx;
    logic             global_correct;
    logic             local_correct;
    logic             update_ready;
    logic             init_done;

    tournament_choice_ctrl #(.IDX_W(IDX_W), .INIT_STATE(2'b01), .UPD_DEPTH(DEPTH)) dut (
        .clk               (clk),
        .reset             (reset),
        .lookup_v          (lookup_v),
        .lookup_idx        (lookup_idx),
        .lookup_ready      (lookup_ready),
        .choice_v          (choice_v),
        .choice_prediction (choice_prediction),
        .update_v          (update_v),
        .update_idx        (update_idx),
        .global_correct    (global_correct),
        .local_correct     (local_correct),
        .update_ready      (update_ready),
        .init_done         (init_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        bit g;
        bit l;
    } mupd_t;

    int    checks = 0;
    int    errors = 0;
    int    m_tab [N];
    mupd_t m_q [$];
    int    m_init_cnt = 0;
    int    m_init_done = 0;
    int    m_cv = 0;
    int    m_cp = 0;
    bit    m_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int apply(input int c, input bit g, input bit l);
        if (g && !l) return (c < 3) ? c + 1 : 3;
        if (!g && l) return (c > 0) ? c - 1 : 0;
        return c;
    endfunction

    function automatic int peek(input int idx);
        int v;
        v = m_tab[idx];
`ifdef CHOICE_FWD_EN
        foreach (m_q[k])
            if (m_q[k].idx == idx) v = apply(v, m_q[k].g, m_q[k].l);
`endif
        return v;
    endfunction

    // Advance the model across the coming rising edge using the inputs currently driven.
    task automatic model_step();
        bit room, lacc, uacc;
        mupd_t h;
        mupd_t n;
        if (reset) begin
            m_q.delete();
            m_init_cnt  = 0;
            m_init_done = 0;
            m_cv        = 0;
            m_cp        = 0;
            m_valid     = 1'b1;
            return;
        end
        if (!m_valid) return;
        if (m_init_done == 0) begin
            m_tab[m_init_cnt] = 1;
            m_init_cnt++;
            if (m_init_cnt == N) m_init_done = 1;
            m_cv = 0;
            return;
        end
        room = (m_q.size() < DEPTH);
        lacc = lookup_v && room;
        uacc = update_v && room;
        m_cv = int'(lacc);
        if (lacc) begin
            m_cp = peek(int'(lookup_idx));
        end else if (m_q.size() > 0) begin
            h = m_q.pop_front();
            m_tab[h.idx] = apply(m_tab[h.idx], h.g, h.l);
        end
        if (uacc) begin
            n.idx = int'(update_idx);
            n.g   = global_correct;
            n.l   = local_correct;
            m_q.push_back(n);
        end
    endtask

    task automatic cycle();
        int rdy;
        if (m_valid) begin
            rdy = (m_init_done != 0 && m_q.size() < DEPTH) ? 1 : 0;
            chk("lookup_ready", 32'(lookup_ready), rdy);
            chk("update_ready", 32'(update_ready), rdy);
            chk("init_done", 32'(init_done), m_init_done);
            chk("choice_v", 32'(choice_v), m_cv);
            chk("choice_prediction", 32'(choice_prediction), m_cp);
        end
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_in(input bit lv, input int li, input bit uv, input int ui, input bit g, input bit l);
        lookup_v       = lv;
        lookup_idx     = IDX_W'(li);
        update_v       = uv;
        update_idx     = IDX_W'(ui);
        global_correct = g;
        local_correct  = l;
    endtask

    task automatic idle(input int n);
        set_in(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic lookup_expect(input int idx, input int exp, input string name);
        set_in(1, idx, 0, 0, 0, 0);
        cycle();
        chk({name, "_v"}, 32'(choice_v), 1);
        chk(name, 32'(choice_prediction), exp);
        set_in(0, 0, 0, 0, 0, 0);
    endtask

    task automatic init_seq();
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        cycle();
        chk("rst_lookup_ready", 32'(lookup_ready), 0);
        chk("rst_update_ready", 32'(update_ready), 0);
        chk("rst_choice_v", 32'(choice_v), 0);
        chk("rst_choice_prediction", 32'(choice_prediction), 0);
        reset = 1'b0;
        for (int k = 0; k <= N; k++) begin
            chk("init_done_cycle", 32'(init_done), (k == N) ? 1 : 0);
            if (k < N) cycle();
        end
    endtask

    initial begin
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        init_seq();

        for (int i = 0; i < N; i++) lookup_expect(i, 1, "init_value");

        // saturate up on idx 5
        for (int i = 0; i < 3; i++) begin set_in(0, 0, 1, 5, 1, 0); cycle(); end
        idle(4);
        lookup_expect(5, 3, "sat_up");
        set_in(0, 0, 1, 5, 1, 0); cycle();
        idle(3);
        lookup_expect(5, 3, "sat_up_hold");

        // saturate down and neutral updates on idx 2
        for (int i = 0; i < 3; i++) begin set_in(0, 0, 1, 2, 0, 1); cycle(); end
        idle(4);
        lookup_expect(2, 0, "sat_down");
        set_in(0, 0, 1, 2, 1, 1); cycle();
        set_in(0, 0, 1, 2, 0, 0); cycle();
        idle(3);
        lookup_expect(2, 0, "no_change");

        // fill the FIFO while lookups hold the port
        set_in(1, 0, 1, 7, 1, 0); cycle();
        set_in(1, 1, 1, 8, 1, 1); cycle();
        set_in(1, 2, 1, 7, 1, 0); cycle();
        set_in(1, 3, 1, 8, 0, 0); cycle();
        set_in(1, 4, 0, 0, 0, 0);
        chk("full_lookup_ready", 32'(lookup_ready), 0);
        chk("full_update_ready", 32'(update_ready), 0);
        cycle();
        chk("after_drain_lookup_ready", 32'(lookup_ready), 1);
        chk("after_drain_update_ready", 32'(update_ready), 1);
        idle(5);
        lookup_expect(7, 3, "full_no_loss");

        // reset with updates still queued
        for (int i = 0; i < 2; i++) begin set_in(0, 0, 1, 3, 1, 0); cycle(); end
        idle(3);
        lookup_expect(3, 3, "pre_reset_idx3");
        set_in(1, 0, 1, 3, 0, 1); cycle();
        set_in(1, 0, 1, 3, 0, 1); cycle();
        init_seq();
        idle(4);
        lookup_expect(3, 1, "post_reset_idx3");

        // lookup of idx 9 with one increment still queued
        set_in(1, 0, 1, 9, 1, 0); cycle();
        set_in(1, 9, 0, 0, 0, 0); cycle();
`ifdef CHOICE_FWD_EN
        chk("fwd_idx9", 32'(choice_prediction), 2);
`else
        chk("fwd_idx9", 32'(choice_prediction), 1);
`endif
        idle(3);
        lookup_expect(9, 2, "drained_idx9");

        // randomized traffic, lookup density varying per block to exercise full/drain paths
        for (int blk = 0; blk < 15; blk++) begin
            int lv_pct;
            lv_pct = (blk % 3 == 0) ? 95 : ((blk % 3 == 1) ? 50 : 10);
            for (int n = 0; n < 200; n++) begin
                reset          = ($urandom_range(0, 399) == 0);
                lookup_v       = ($urandom_range(0, 99) < lv_pct);
                lookup_idx     = IDX_W'($urandom_range(0, ($urandom_range(0, 1) == 0) ? 3 : 15));
                update_v       = ($urandom_range(0, 1) == 1);
                update_idx     = IDX_W'($urandom_range(0, ($urandom_range(0, 1) == 0) ? 3 : 15));
                global_correct = $urandom_range(0, 1) == 1;
                local_correct  = $urandom_range(0, 1) == 1;
                cycle();
            end
        end
        reset = 1'b0;
        idle(24);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
